rr_encoder8: RTL and testbench
==============================

RR_ENCODER8 -- requirements
Module: rr_encoder8

Interface
REQ-001 Parameter PTR_RESET, default 3'd0, round-robin pointer value loaded on reset.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  8  request lines; bit i requests index i.
REQ-005 code_ready  input  1  downstream (3-to-8 decoder stage) accepts code this cycle.
REQ-006 code  output  3  binary index of granted request, I2..I0 order (code[2] = MSB).
REQ-007 code_valid  output  1  code holds a valid grant.
REQ-008 ptr  output  3  current round-robin search start, for observation.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (code_valid=0) and OFFER (code_valid=1).
REQ-010 In IDLE, at a rising edge with req != 0, the block SHALL register the first set bit in search order ptr, ptr+1, ..., ptr+7 (mod 8) into code, set code_valid=1, and enter OFFER.
REQ-011 In IDLE with req == 0, the block SHALL remain in IDLE with code and ptr unchanged.
REQ-012 Latency SHALL be one clock: req sampled at edge N gives code_valid=1 after edge N.
REQ-013 In OFFER with code_ready=0, code and code_valid SHALL hold stable regardless of req changes, including withdrawal of the granted bit.
REQ-014 In OFFER with code_ready=1 at an edge (handshake), the block SHALL clear code_valid, set ptr to code+1 mod 8 (7 wraps to 0), and return to IDLE.
REQ-015 Maximum throughput SHALL be one grant per two cycles; no new grant is made in the handshake cycle.
REQ-016 code_ready while in IDLE SHALL have no effect.
REQ-017 Search SHALL wrap from index 7 to 0; a single requester SHALL be granted whatever ptr is.
REQ-018 ptr SHALL change only on a handshake.

Reset
REQ-019 rst=1 SHALL immediately, independent of clk, force state=IDLE, code_valid=0, code=3'b000, ptr=PTR_RESET.
REQ-020 Reset asserted in OFFER SHALL drop the pending grant without advancing ptr.
REQ-021 After rst deasserts, the first grant SHALL occur at the first rising edge with req != 0.

Structure
REQ-022 A shared package SHALL hold the state encoding (IDLE=1'b0, OFFER=1'b1) and width constants (REQ_W=8, CODE_W=3).
REQ-023 The rotate-and-priority search SHALL be a combinational sub-module rr_pick8 (inputs req, ptr; outputs idx, any).
REQ-024 The code/code_valid outputs SHALL come straight from registers, with no combinational path from req or code_ready.

Verification
REQ-025 Reset, req=8'b0000_0001, code_ready=1 -> code=0, code_valid=1 after one edge; ptr=1 after handshake.
REQ-026 req=8'hFF held, code_ready=1 -> codes 0,1,2,...,7,0 in sequence, one grant every two cycles.
REQ-027 req=8'b1000_0100 from ptr=0, code_ready=1 -> grants 2, 7, 2, 7.
REQ-028 Grant code=2, code_ready=0 for 5 cycles while req changes to 8'h01 -> code=2, code_valid=1 stable; after code_ready=1 -> ptr=3, next grant 0.
REQ-029 rst pulsed mid-OFFER (code=5) -> code_valid=0 and ptr=PTR_RESET before the next clock edge.
REQ-030 req=0 for 10 cycles -> code_valid stays 0 and ptr is unchanged.

Source files
------------

// File: rtl/rr_encoder8_pkg.sv
// Shared widths and FSM encoding for the 8-way round-robin encoder.
package rr_encoder8_pkg;

    localparam int REQ_W  = 8;
    localparam int CODE_W = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotate-and-priority search: first set req bit at ptr, ptr+1, ... ptr+7 (mod 8).
// No state, zero latency; any=0 when no request is set (idx then reads 0).
module rr_pick8
    import rr_encoder8_pkg::*;
(
    input  logic [REQ_W-1:0]  req,
    input  logic [CODE_W-1:0] ptr,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    logic [CODE_W-1:0] cand;

    // Walk from the farthest offset back to ptr so the nearest hit is written last and wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = REQ_W - 1; k >= 0; k--) begin
            cand = ptr + k[CODE_W-1:0];
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_encoder8.sv
// Round-robin 8:3 encoder; grant registered one clock after req is sampled in IDLE.
// Grant held stable until code_ready; at most one grant every two cycles.
module rr_encoder8
    import rr_encoder8_pkg::*;
#(
    parameter logic [CODE_W-1:0] PTR_RESET = 3'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQ_W-1:0]  req,
    input  logic              code_ready,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic [CODE_W-1:0] ptr
);

    logic [0:0]        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] ptr_q, ptr_d;
    logic [CODE_W-1:0] pick_idx;
    logic              pick_any;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    code_d  = pick_idx;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // req is ignored here so the offered code cannot change under the consumer.
                if (code_ready) begin
                    ptr_d   = code_q + 3'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            ptr_q   <= PTR_RESET;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ptr_q   <= ptr_d;
        end
    end

    assign code       = code_q;
    assign code_valid = (state_q == ST_OFFER);
    assign ptr        = ptr_q;

endmodule

// File: tb/tb_rr_encoder8.sv
// Scoreboard bench for rr_encoder8: expected grants queued as req is driven, popped as codes appear.
module tb_rr_encoder8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       code_ready;
    logic [2:0] code;
    logic       code_valid;
    logic [2:0] ptr;

    int chk_cnt;
    int pass_cnt;

    logic [2:0] exp_q[$];
    logic [2:0] exp_code;

    rr_encoder8 #(.PTR_RESET(3'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .code_ready (code_ready),
        .code       (code),
        .code_valid (code_valid),
        .ptr        (ptr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = 8'h00;
        code_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        chk_cnt++;
        if (code_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", code_valid);
        else pass_cnt++;
        chk_cnt++;
        if (code !== 3'd0) $display("FAIL reset_code: got %0d want 0", code);
        else pass_cnt++;
        chk_cnt++;
        if (ptr !== 3'd0) $display("FAIL reset_ptr: got %0d want 0", ptr);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Single requester, ready already high: grant after one edge, handshake on the next.
    task automatic test_single();
        req = 8'b0000_0001;
        code_ready = 1'b1;
        exp_q.push_back(3'd0);
        @(posedge clk); #1;
        exp_code = exp_q.pop_front();
        chk_cnt++;
        if (code_valid !== 1'b1 || code !== exp_code)
            $display("FAIL single_grant: got v=%b code=%0d want v=1 code=%0d", code_valid, code, exp_code);
        else pass_cnt++;
        chk_cnt++;
        if (ptr !== 3'd0) $display("FAIL single_ptr_hold: got %0d want 0", ptr);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (code_valid !== 1'b0) $display("FAIL single_hs_valid: got %b want 0", code_valid);
        else pass_cnt++;
        chk_cnt++;
        if (ptr !== 3'd1) $display("FAIL single_hs_ptr: got %0d want 1", ptr);
        else pass_cnt++;
        req = 8'h00;
    endtask

    // Held request pattern with ready high: alternate grant / handshake cycles.
    task automatic test_stream(input string name, input logic [7:0] r, input logic [2:0] exp_tbl[]);
        foreach (exp_tbl[i]) exp_q.push_back(exp_tbl[i]);
        req = r;
        code_ready = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            exp_code = exp_q.pop_front();
            chk_cnt++;
            if (code_valid !== 1'b1 || code !== exp_code)
                $display("FAIL %s_grant: got v=%b code=%0d want v=1 code=%0d", name, code_valid, code, exp_code);
            else pass_cnt++;
            @(posedge clk); #1;
            chk_cnt++;
            if (code_valid !== 1'b0 || ptr !== exp_code + 3'd1)
                $display("FAIL %s_handshake: got v=%b ptr=%0d want v=0 ptr=%0d", name, code_valid, ptr, exp_code + 3'd1);
            else pass_cnt++;
        end
        req = 8'h00;
    endtask

    task automatic test_back_to_back();
        logic [2:0] tbl_all[] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        logic [2:0] tbl_two[] = '{3'd2, 3'd7, 3'd2, 3'd7};
        do_reset();
        test_stream("all_ones", 8'hFF, tbl_all);
        do_reset();
        test_stream("two_req", 8'b1000_0100, tbl_two);
    endtask

    // Stall while req is rewritten, including withdrawal of the granted bit.
    task automatic test_stall();
        do_reset();
        req = 8'b0000_0100;
        code_ready = 1'b0;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd0);
        @(posedge clk); #1;
        req = 8'h01;
        exp_code = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            chk_cnt++;
            if (code_valid !== 1'b1 || code !== exp_code)
                $display("FAIL stall_hold%0d: got v=%b code=%0d want v=1 code=%0d", c, code_valid, code, exp_code);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        code_ready = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if (code_valid !== 1'b0 || ptr !== 3'd3)
            $display("FAIL stall_release: got v=%b ptr=%0d want v=0 ptr=3", code_valid, ptr);
        else pass_cnt++;
        @(posedge clk); #1;
        exp_code = exp_q.pop_front();
        chk_cnt++;
        if (code_valid !== 1'b1 || code !== exp_code)
            $display("FAIL stall_wrap_grant: got v=%b code=%0d want v=1 code=%0d", code_valid, code, exp_code);
        else pass_cnt++;
        req = 8'h00;
        @(posedge clk); #1;
        chk_cnt++;
        if (ptr !== 3'd1) $display("FAIL stall_wrap_ptr: got %0d want 1", ptr);
        else pass_cnt++;
    endtask

    // Reset mid-offer must clear outputs without waiting for a clock edge.
    task automatic test_rst_mid_offer();
        req = 8'b0010_0000;
        code_ready = 1'b0;
        @(posedge clk); #1;
        chk_cnt++;
        if (code_valid !== 1'b1 || code !== 3'd5)
            $display("FAIL rst_setup: got v=%b code=%0d want v=1 code=5", code_valid, code);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        chk_cnt++;
        if (code_valid !== 1'b0 || ptr !== 3'd0 || code !== 3'd0)
            $display("FAIL rst_async: got v=%b ptr=%0d code=%0d want v=0 ptr=0 code=0", code_valid, ptr, code);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        req = 8'h00;
    endtask

    // Idle with ready high must neither grant nor move ptr.
    task automatic test_idle();
        req = 8'b0000_1000;
        code_ready = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if (code_valid !== 1'b1 || code !== 3'd3)
            $display("FAIL idle_first_grant: got v=%b code=%0d want v=1 code=3", code_valid, code);
        else pass_cnt++;
        req = 8'h00;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (code_valid !== 1'b0 || ptr !== 3'd4)
                $display("FAIL idle_cycle%0d: got v=%b ptr=%0d want v=0 ptr=4", c, code_valid, ptr);
            else pass_cnt++;
        end
    endtask

    initial begin
        chk_cnt    = 0;
        pass_cnt   = 0;
        rst        = 1'b1;
        req        = 8'h00;
        code_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_rst_mid_offer();
        test_idle();
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
